// File: rtl/pr3_pkg.sv
// pr3_pkg: shared types for the peak result framer.
// FRAME_CHECKSUM_EN adds the trailing SUM byte and its FSM state.
package pr3_pkg;
  typedef struct packed {
    logic [23:0] freq;
    logic [15:0] phaseA;
    logic [15:0] phaseB;
  } peak_t;
  localparam int ENTRY_BYTES = 7;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_CNT, TX_DATA, TX_SUM} tx_state_t;
`else
  localparam bit CSUM_EN = 1'b0;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_CNT, TX_DATA} tx_state_t;
`endif
  // byte 0 is freq[23:16], byte 6 is phaseB[7:0]
  function automatic logic [7:0] peak_byte(peak_t p, logic [2:0] k);
    logic [55:0] v;
    v = p >> {3'(ENTRY_BYTES - 1) - k, 3'b000};
    return v[7:0];
  endfunction
endpackage

// File: rtl/peak_bank.sv
// peak_bank: two ping-pong banks of peak entries with per-bank count,
// commit flags and a head pointer naming the oldest committed bank.
module peak_bank import pr3_pkg::*; #(
  parameter int MAXPEAKS = 4,
  localparam int IW = (MAXPEAKS > 1) ? $clog2(MAXPEAKS) : 1,
  localparam int CW = $clog2(MAXPEAKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [IW-1:0] wr_idx,
  input  peak_t         wr_data,
  input  logic          commit_en,
  input  logic          commit_bank,
  input  logic [CW-1:0] commit_cnt,
  input  logic          free_en,
  input  logic [IW-1:0] rd_idx,
  output logic [1:0]    committed_o,
  output logic          head_o,
  output logic [CW-1:0] head_cnt_o,
  output peak_t         rd_data_o
);
  peak_t mem_q [2][MAXPEAKS];
  logic [CW-1:0] cnt_q [2];
  logic [1:0] committed_q, committed_d;
  logic head_q, head_d;
  always_comb begin
    committed_d = committed_q;
    if (free_en) committed_d[head_q] = 1'b0;
    if (commit_en) committed_d[commit_bank] = 1'b1;
  end
  // freeing the head always hands over to the other bank; an empty pair adopts the new commit
  assign head_d = free_en ? !head_q : (commit_en && committed_q == 2'b00) ? commit_bank : head_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      committed_q <= '0;
      head_q <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      committed_q <= committed_d;
      head_q <= head_d;
      if (commit_en) cnt_q[commit_bank] <= commit_cnt;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_bank][wr_idx] <= wr_data;
  assign committed_o = committed_q;
  assign head_o = head_q;
  assign head_cnt_o = cnt_q[head_q];
  assign rd_data_o = mem_q[head_q][rd_idx];
endmodule

// File: rtl/peak_frame_tx.sv
// peak_frame_tx: captures peak result frames into ping-pong banks and streams them as bytes.
// Define FRAME_CHECKSUM_EN to append a two's-complement checksum byte to each frame.
module peak_frame_tx import pr3_pkg::*; #(
  parameter int MAXPEAKS = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic [23:0] sink_freq,
  input  logic [15:0] sink_phaseA,
  input  logic [15:0] sink_phaseB,
  output logic        source_valid,
  input  logic        source_ready,
  output logic [7:0]  source_data,
  output logic        source_last,
  output logic [7:0]  drop_cnt,
  output logic        busy
);
  localparam int IW = (MAXPEAKS > 1) ? $clog2(MAXPEAKS) : 1;
  localparam int CW = $clog2(MAXPEAKS + 1);
  localparam logic [2:0] LAST_BYTE = 3'(ENTRY_BYTES - 1);
  tx_state_t state_q;
  logic valid_q, last_q, open_q, bank_q;
  logic [7:0] data_q, drop_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] sum_q;
`endif
  logic [IW-1:0] ent_q, nxt_ent;
  logic [2:0] byt_q, nxt_byt;
  logic [CW-1:0] widx_q, idx, nidx, head_cnt;
  logic [1:0] committed, avail;
  logic head, acc, free_en, sop_go, start, act, cap_bank, wr_en, commit_en, last_data, nxt_last;
  peak_t rd_data;
  assign acc = valid_q && source_ready;
  assign free_en = acc && last_q;
  // a bank released by this cycle's final accept is already usable by a sop
  assign avail = ~committed | ({1'b0, free_en} << head);
  assign sop_go = sink_valid && sink_sop;
  assign cap_bank = open_q ? bank_q : !avail[0];
  assign start = sop_go && (open_q || avail != 2'b00);
  assign act = start || (sink_valid && open_q);
  assign idx = start ? '0 : widx_q;
  assign wr_en = act && idx < CW'(MAXPEAKS);
  assign nidx = wr_en ? idx + 1'b1 : idx;
  assign commit_en = act && sink_eop;
  assign last_data = (CW'(ent_q) + 1'b1 == head_cnt) && byt_q == LAST_BYTE;
  assign nxt_byt = (state_q == TX_DATA && byt_q != LAST_BYTE) ? byt_q + 1'b1 : '0;
  assign nxt_ent = state_q != TX_DATA ? '0 : byt_q == LAST_BYTE ? ent_q + 1'b1 : ent_q;
  assign nxt_last = !CSUM_EN && (CW'(nxt_ent) + 1'b1 == head_cnt) && nxt_byt == LAST_BYTE;
  peak_bank #(.MAXPEAKS(MAXPEAKS)) u_bank (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_bank(cap_bank), .wr_idx(idx[IW-1:0]),
    .wr_data('{freq: sink_freq, phaseA: sink_phaseA, phaseB: sink_phaseB}),
    .commit_en(commit_en), .commit_bank(cap_bank), .commit_cnt(nidx),
    .free_en(free_en), .rd_idx(nxt_ent),
    .committed_o(committed), .head_o(head), .head_cnt_o(head_cnt), .rd_data_o(rd_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      open_q <= 1'b0;
      bank_q <= 1'b0;
      widx_q <= '0;
      drop_q <= '0;
    end else begin
      open_q <= act ? !sink_eop : open_q;
      bank_q <= start ? cap_bank : bank_q;
      widx_q <= act ? nidx : widx_q;
      drop_q <= (sop_go && !start && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= TX_IDLE;
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ent_q <= '0;
      byt_q <= '0;
`ifdef FRAME_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      case (state_q)
        TX_IDLE: if (committed != 2'b00 || commit_en) begin
          state_q <= TX_HDR;
          valid_q <= 1'b1;
          data_q <= HEADER;
        end
        TX_HDR: if (acc) begin
          state_q <= TX_CNT;
          data_q <= 8'(head_cnt);
        end
        TX_CNT: if (acc) begin
          state_q <= TX_DATA;
          ent_q <= '0;
          byt_q <= '0;
`ifdef FRAME_CHECKSUM_EN
          sum_q <= data_q;
`endif
          data_q <= peak_byte(rd_data, 3'd0);
          last_q <= nxt_last;
        end
        TX_DATA: if (acc) begin
          if (last_data) begin
`ifdef FRAME_CHECKSUM_EN
            state_q <= TX_SUM;
            data_q <= 8'd0 - (sum_q + data_q);
            last_q <= 1'b1;
`else
            state_q <= TX_IDLE;
            valid_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
`endif
          end else begin
            ent_q <= nxt_ent;
            byt_q <= nxt_byt;
            data_q <= peak_byte(rd_data, nxt_byt);
            last_q <= nxt_last;
`ifdef FRAME_CHECKSUM_EN
            sum_q <= sum_q + data_q;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        TX_SUM: if (acc) begin
          state_q <= TX_IDLE;
          valid_q <= 1'b0;
          data_q <= '0;
          last_q <= 1'b0;
        end
`endif
        default: state_q <= TX_IDLE;
      endcase
    end
  assign source_valid = valid_q;
  assign source_data = data_q;
  assign source_last = last_q;
  assign drop_cnt = drop_q;
  assign busy = committed != 2'b00 || state_q != TX_IDLE;
endmodule

// File: tb/tb_peak_frame_tx.sv
// tb_peak_frame_tx: vector table, directed corner sequences and random traffic against a frame-level model.
module tb_peak_frame_tx;
  localparam int MAXP = 4;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef FRAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic sink_valid = 0, sink_sop = 0, sink_eop = 0, source_ready = 0;
  logic [23:0] sink_freq = '0;
  logic [15:0] sink_phaseA = '0, sink_phaseB = '0;
  logic source_valid, source_last, busy;
  logic [7:0] source_data, drop_cnt;
  int errors = 0, checks = 0, frames_done = 0;

  always #5 clk = ~clk;

  peak_frame_tx #(.MAXPEAKS(MAXP), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_freq(sink_freq), .sink_phaseA(sink_phaseA), .sink_phaseB(sink_phaseB),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_data(source_data), .source_last(source_last),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame-level reference: whole frames are queued as expected byte streams
  typedef struct {logic [7:0] d; logic l;} ob_t;
  ob_t exp_q[$];
  logic [55:0] cur[$];
  logic [7:0] frame_log[$], last_frame[$];
  bit open_m, gap, pv, pr, pl;
  logic [7:0] pd;
  int pend, drop_m;

  task automatic push_frame();
    logic [7:0] sum, b;
    exp_q.push_back('{HDR, 1'b0});
    exp_q.push_back('{8'(cur.size()), 1'b0});
    sum = 8'(cur.size());
    foreach (cur[i])
      for (int k = 0; k < 7; k++) begin
        b = cur[i][55 - 8*k -: 8];
        sum += b;
        exp_q.push_back('{b, 1'b0});
      end
    if (CS != 0) exp_q.push_back('{8'd0 - sum, 1'b1});
    else exp_q[exp_q.size() - 1].l = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", source_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_last", source_last, 0);
      chk("rst_data", source_data, 0);
      exp_q.delete(); cur.delete(); frame_log.delete();
      open_m = 0; gap = 0; pv = 0; pend = 0; drop_m = 0;
    end else begin
      chk("valid", source_valid, (pend > 0 && !gap) ? 1 : 0);
      chk("busy", busy, pend > 0 ? 1 : 0);
      chk("drop_cnt", drop_cnt, drop_m);
      if (pv && !pr && source_valid) begin
        chk("hold_data", source_data, pd);
        chk("hold_last", source_last, pl);
      end
      gap = 0;
      if (source_valid && source_ready) begin
        chk("byte_expected", exp_q.size() > 0 ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          ob_t o;
          o = exp_q.pop_front();
          chk("data", source_data, o.d);
          chk("last", source_last, o.l);
          frame_log.push_back(source_data);
          if (o.l) begin
            last_frame = frame_log;
            frame_log.delete();
            pend--;
            gap = 1;
            frames_done++;
          end
        end
      end
      pv = source_valid; pr = source_ready; pd = source_data; pl = source_last;
      if (sink_valid) begin
        if (sink_sop) begin
          if (open_m) cur.delete();
          else if (pend < 2) begin open_m = 1; cur.delete(); end
          else if (drop_m < 255) drop_m++;
        end
        if (open_m && cur.size() < MAXP) cur.push_back({sink_freq, sink_phaseA, sink_phaseB});
        if (open_m && sink_eop) begin
          push_frame();
          pend++;
          open_m = 0;
        end
      end
    end
  end

  typedef struct {
    logic v, s, e, r;
    logic [23:0] f;
    logic [15:0] a, b;
    logic ev, el, eb;
    logic [7:0] ed;
  } vec_t;
  vec_t tv[12];

  function automatic vec_t row(logic ev, logic [7:0] ed, logic el, logic eb);
    vec_t x = '{v: 0, s: 0, e: 0, r: 1, f: '0, a: '0, b: '0, ev: ev, el: el, eb: eb, ed: ed};
    return x;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic drive(logic v, logic s, logic e, logic [23:0] f, logic [15:0] a, logic [15:0] b);
    sink_valid = v; sink_sop = s; sink_eop = e; sink_freq = f; sink_phaseA = a; sink_phaseB = b;
  endtask
  task automatic idle(); drive(0, 0, 0, '0, '0, '0); endtask
  task automatic wait_frames(int n, int budget);
    for (int i = 0; i < budget && frames_done < n; i++) tick();
    chk("frame_timeout", frames_done, n);
  endtask

  initial begin
    logic [7:0] sb [9];
    int base;
    sb = '{8'hA5, 8'h01, 8'h01, 8'h86, 8'hA0, 8'h40, 8'h00, 8'hC0, 8'h00};
    tv[0] = row(0, 8'h00, 0, 0);
    tv[0].v = 1; tv[0].s = 1; tv[0].e = 1;
    tv[0].f = 24'h0186A0; tv[0].a = 16'h4000; tv[0].b = 16'hC000;
    for (int i = 1; i <= 9; i++) tv[i] = row(1, sb[i-1], (i == 9 && CS == 0) ? 1'b1 : 1'b0, 1);
    tv[10] = (CS != 0) ? row(1, 8'hD8, 1, 1) : row(0, 8'h00, 0, 0);
    tv[11] = row(0, 8'h00, 0, 0);

    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].v, tv[i].s, tv[i].e, tv[i].f, tv[i].a, tv[i].b);
      source_ready = tv[i].r;
      @(negedge clk);
      chk($sformatf("tv%0d_valid", i), source_valid, tv[i].ev);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].eb);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_data", i), source_data, tv[i].ed);
        chk($sformatf("tv%0d_last", i), source_last, tv[i].el);
      end
      tick();
    end
    idle();

    base = frames_done;
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, i == 3, 24'($urandom), 16'($urandom), 16'($urandom));
      source_ready = i[0];
      tick();
    end
    idle();
    for (int i = 0; i < 200 && frames_done < base + 1; i++) begin
      source_ready = ~source_ready;
      tick();
    end
    chk("toggle_done", frames_done, base + 1);
    chk("toggle_len", last_frame.size(), 30 + CS);

    source_ready = 0;
    base = frames_done;
    for (int i = 0; i < 6; i++) begin
      drive(1, i % 2 == 0, i % 2 == 1, 24'h300000 + 24'(i), 16'($urandom), 16'($urandom));
      tick();
    end
    idle();
    repeat (3) tick();
    chk("drop_one", drop_cnt, 1);
    chk("stall_valid", source_valid, 1);
    source_ready = 1;
    wait_frames(base + 2, 200);
    chk("two_len", last_frame.size(), 16 + CS);
    chk("drop_hold", drop_cnt, 1);

    base = frames_done;
    for (int i = 0; i < 6; i++) begin
      drive(1, i == 0, i == 5, {8'h10 + 8'(i), 16'h1234}, 16'(i), 16'hBEEF);
      tick();
    end
    idle();
    wait_frames(base + 1, 100);
    chk("sat_cnt", last_frame[1], 4);
    chk("sat_len", last_frame.size(), 30 + CS);
    chk("sat_e3", last_frame[23], 8'h13);

    base = frames_done;
    drive(1, 0, 1, 24'h777777, 16'h7777, 16'h7777); tick();
    drive(1, 1, 0, 24'h111111, 16'h1111, 16'h1111); tick();
    drive(1, 0, 0, 24'h222222, 16'h2222, 16'h2222); tick();
    drive(1, 1, 1, 24'hABCDEF, 16'h1357, 16'h2468); tick();
    idle();
    wait_frames(base + 1, 100);
    repeat (10) tick();
    chk("restart_frames", frames_done, base + 1);
    chk("restart_cnt", last_frame[1], 1);
    chk("restart_f", last_frame[2], 8'hAB);
    chk("restart_len", last_frame.size(), 9 + CS);

    drive(1, 1, 0, 24'h0A0B0C, 16'h0D0E, 16'h0F10); tick();
    drive(1, 0, 1, 24'h111213, 16'h1415, 16'h1617); tick();
    idle();
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("arst_valid", source_valid, 0);
    chk("arst_busy", busy, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    base = frames_done;
    drive(1, 1, 1, 24'h0186A0, 16'h4000, 16'hC000); tick();
    idle();
    wait_frames(base + 1, 100);
    chk("post_rst_hdr", last_frame[0], HDR);
    chk("post_rst_len", last_frame.size(), 9 + CS);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            24'($urandom), 16'($urandom), 16'($urandom));
      source_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    idle();
    source_ready = 1;
    for (int i = 0; i < 300 && (busy || exp_q.size() != 0); i++) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
